// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
//   Parametrised, two-stage pipelined video test-pattern generator. Takes the
//   timing generator's active-pixel coordinates and data-enable, and produces
//   a registered pixel word from one of five run-time selectable patterns:
//     0 colour-block grid, 1 checkerboard, 2 grey ramp, 3 bouncing box,
//     4 solid colour, 5-7 black.
//   The pattern mode is latched only at frame start; the box moves once per
//   frame, at frame end, whatever the mode.
//
// Ports
//   clk         in   pixel clock
//   reset       in   synchronous active-high reset
//   de          in   active-pixel enable
//   hcount      in   [CW-1:0] active-region x coordinate (valid when de=1)
//   vcount      in   [CW-1:0] active-region y coordinate (valid when de=1)
//   mode_sel    in   [2:0] requested pattern mode
//   solid_rgb   in   [23:0] RGB888 colour used by mode 4
//   disp_data   out  [DW-1:0] pixel data, RGB888 or RGB565 (zero when !data_valid)
//   data_valid  out  de delayed by two clocks, aligned with disp_data
//   mode_active out  [2:0] pattern mode currently in use
// -----------------------------------------------------------------------------
module pattern_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int CW         = 12,
  parameter int N_COLS     = 2,
  parameter int N_ROWS     = 4,
  parameter int RGB565     = 0,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  parameter int STEP       = 4,
  localparam int DW        = (RGB565 != 0) ? 16 : 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          de,
  input  logic [CW-1:0] hcount,
  input  logic [CW-1:0] vcount,
  input  logic [2:0]    mode_sel,
  input  logic [23:0]   solid_rgb,
  output logic [DW-1:0] disp_data,
  output logic          data_valid,
  output logic [2:0]    mode_active
);

  localparam int COL_W = H_ACTIVE / N_COLS;
  localparam int ROW_H = V_ACTIVE / N_ROWS;

  // Frame events
  logic frame_start;
  logic frame_end;

  assign frame_start = de && (hcount == '0) && (vcount == '0);
  assign frame_end   = de && (hcount == CW'(H_ACTIVE - 1)) && (vcount == CW'(V_ACTIVE - 1));

  // State
  logic [2:0]    mode_active_q, mode_active_d;
  logic [CW-1:0] box_x_q, box_x_d;
  logic [CW-1:0] box_y_q, box_y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic          de1_q, de1_d;
  logic [23:0]   pix_q, pix_d;
  logic          de2_q, de2_d;
  logic [DW-1:0] disp_q, disp_d;

  // Colour-grid decode: one constant comparator per column/row boundary.
  // Thresholds are monotonic, so the number of boundaries passed is the
  // column (row) index. Coordinates past the active area pass every
  // boundary and therefore land in the last column/row, which also absorbs
  // any division remainder.
  logic [N_COLS-1:0] col_ge;
  logic [N_ROWS-1:0] row_ge;
  logic [4:0]        col_idx;
  logic [4:0]        row_idx;

  assign col_ge[0] = 1'b0;
  assign row_ge[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < N_COLS; gi++) begin : g_col
      assign col_ge[gi] = (hcount >= CW'(gi * COL_W));
    end
    for (gi = 1; gi < N_ROWS; gi++) begin : g_row
      assign row_ge[gi] = (vcount >= CW'(gi * ROW_H));
    end
  endgenerate

  always_comb begin
    col_idx = '0;
    for (int i = 0; i < N_COLS; i++) begin
      col_idx = col_idx + {4'd0, col_ge[i]};
    end
    row_idx = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      row_idx = row_idx + {4'd0, row_ge[i]};
    end
  end

  // Pattern sources
  logic [2:0]  grid_idx;
  logic [23:0] grid_rgb;
  logic        checker_on;
  logic [7:0]  grey;
  logic        in_box_x;
  logic        in_box_y;
  logic [2:0]  eff_mode;

  always_comb begin
    grid_idx   = 3'(row_idx * N_COLS + col_idx);
    // idx bit 0 -> blue, bit 1 -> red, bit 2 -> green
    grid_rgb   = {{8{grid_idx[1]}}, {8{grid_idx[2]}}, {8{grid_idx[0]}}};
    checker_on = hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2];
    // 51/256 ~ 255/1280: ramps 0..254 across the line without a divider
    grey       = 8'((32'(hcount) * 51) >> 8);
    // one extra bit so box_x + BOX_SIZE cannot wrap
    in_box_x   = ({1'b0, hcount} >= {1'b0, box_x_q}) &&
                 ({1'b0, hcount} <  ({1'b0, box_x_q} + (CW+1)'(BOX_SIZE)));
    in_box_y   = ({1'b0, vcount} >= {1'b0, box_y_q}) &&
                 ({1'b0, vcount} <  ({1'b0, box_y_q} + (CW+1)'(BOX_SIZE)));
    // The frame-start pixel already uses the newly requested mode.
    eff_mode   = frame_start ? mode_sel : mode_active_q;
  end

  // Stage 1: pattern decode to RGB888
  always_comb begin
    pix_d = '0;
    unique case (eff_mode)
      3'd0: pix_d = grid_rgb;
      3'd1: pix_d = checker_on ? 24'hFFFFFF : 24'h000000;
      3'd2: pix_d = {grey, grey, grey};
      3'd3: pix_d = (in_box_x && in_box_y) ? 24'hFFFFFF : 24'h0000FF;
      3'd4: pix_d = solid_rgb;
      default: pix_d = '0;
    endcase
    de1_d         = de;
    mode_active_d = frame_start ? mode_sel : mode_active_q;
  end

  // Box motion: bounce against the active-area edges, both axes together.
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (frame_end) begin
      if (dir_x_q) begin
        if (int'(box_x_q) + STEP + BOX_SIZE > H_ACTIVE) begin
          box_x_d = CW'(H_ACTIVE - BOX_SIZE);
          dir_x_d = 1'b0;
        end else begin
          box_x_d = box_x_q + CW'(STEP);
        end
      end else begin
        if (int'(box_x_q) < STEP) begin
          box_x_d = '0;
          dir_x_d = 1'b1;
        end else begin
          box_x_d = box_x_q - CW'(STEP);
        end
      end
      if (dir_y_q) begin
        if (int'(box_y_q) + STEP + BOX_SIZE > V_ACTIVE) begin
          box_y_d = CW'(V_ACTIVE - BOX_SIZE);
          dir_y_d = 1'b0;
        end else begin
          box_y_d = box_y_q + CW'(STEP);
        end
      end else begin
        if (int'(box_y_q) < STEP) begin
          box_y_d = '0;
          dir_y_d = 1'b1;
        end else begin
          box_y_d = box_y_q - CW'(STEP);
        end
      end
    end
  end

  // Stage 2: output formatting and blanking
  assign de2_d = de1_q;

  generate
    if (RGB565 != 0) begin : g_565
      always_comb begin
        disp_d = de1_q ? {pix_q[23:19], pix_q[15:10], pix_q[7:3]} : '0;
      end
      // colour LSBs dropped by RGB565 truncation
      logic unused_lsbs;
      assign unused_lsbs = ^{pix_q[18:16], pix_q[9:8], pix_q[2:0]};
    end else begin : g_888
      always_comb begin
        disp_d = de1_q ? pix_q : '0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_active_q <= '0;
      box_x_q       <= '0;
      box_y_q       <= '0;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      de1_q         <= 1'b0;
      pix_q         <= '0;
      de2_q         <= 1'b0;
      disp_q        <= '0;
    end else begin
      mode_active_q <= mode_active_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      de1_q         <= de1_d;
      pix_q         <= pix_d;
      de2_q         <= de2_d;
      disp_q        <= disp_d;
    end
  end

  assign disp_data   = disp_q;
  assign data_valid  = de2_q;
  assign mode_active = mode_active_q;

endmodule

// File: tb/tb_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen
//   Drives an RGB888 and an RGB565 instance of pattern_gen with identical
//   stimulus. Frames are sparse: only the pixels of interest plus the
//   frame-start (0,0) and frame-end (1279,719) pixels are presented, which is
//   all the design needs to see to latch modes and move the box.
// -----------------------------------------------------------------------------
module tb_pattern_gen;

  localparam int H   = 1280;
  localparam int V   = 720;
  localparam int BOX = 64;
  localparam int STP = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        de        = 1'b0;
  logic [11:0] hcount    = '0;
  logic [11:0] vcount    = '0;
  logic [2:0]  mode_sel  = '0;
  logic [23:0] solid_rgb = '0;

  logic [23:0] dd24;
  logic        dv24;
  logic [2:0]  ma24;
  logic [15:0] dd16;
  logic        dv16;
  logic [2:0]  ma16;

  pattern_gen #(.RGB565(0)) dut (
    .clk(clk), .reset(reset), .de(de), .hcount(hcount), .vcount(vcount),
    .mode_sel(mode_sel), .solid_rgb(solid_rgb),
    .disp_data(dd24), .data_valid(dv24), .mode_active(ma24)
  );

  pattern_gen #(.RGB565(1)) dut565 (
    .clk(clk), .reset(reset), .de(de), .hcount(hcount), .vcount(vcount),
    .mode_sel(mode_sel), .solid_rgb(solid_rgb),
    .disp_data(dd16), .data_valid(dv16), .mode_active(ma16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [23:0] rgb;
    int          h;
    int          v;
  } exp_t;

  typedef struct {
    logic        d;
    int          h;
    int          v;
    logic [2:0]  sel;
    logic [23:0] solid;
    logic [23:0] rgb;
    logic [2:0]  mode;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  // reference state
  logic [2:0] m_mode = '0;
  int         m_bx   = 0;
  int         m_by   = 0;
  bit         m_dx   = 1'b1;
  bit         m_dy   = 1'b1;

  function automatic logic [15:0] to565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  function automatic logic [23:0] model_pixel(input int h, input int v, input logic [2:0] mode,
                                              input logic [23:0] solid, input int bx, input int by);
    int c, r, idx, g;
    logic [7:0] rr, gg, bb;
    case (mode)
      3'd0: begin
        c = h / (H / 2); if (c > 1) c = 1;
        r = v / (V / 4); if (r > 3) r = 3;
        idx = (r * 2 + c) % 8;
        bb = ((idx & 1) != 0) ? 8'hFF : 8'h00;
        rr = ((idx & 2) != 0) ? 8'hFF : 8'h00;
        gg = ((idx & 4) != 0) ? 8'hFF : 8'h00;
        return {rr, gg, bb};
      end
      3'd1: return ((((h / 32) ^ (v / 32)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3'd2: begin
        g = ((h * 51) / 256) % 256;
        return {g[7:0], g[7:0], g[7:0]};
      end
      3'd3: return (h >= bx && h < bx + BOX && v >= by && v < by + BOX) ? 24'hFFFFFF : 24'h0000FF;
      3'd4: return solid;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic box_move();
    if (m_dx) begin
      if (m_bx + STP + BOX > H) begin m_bx = H - BOX; m_dx = 1'b0; end
      else m_bx = m_bx + STP;
    end else begin
      if (m_bx < STP) begin m_bx = 0; m_dx = 1'b1; end
      else m_bx = m_bx - STP;
    end
    if (m_dy) begin
      if (m_by + STP + BOX > V) begin m_by = V - BOX; m_dy = 1'b0; end
      else m_by = m_by + STP;
    end else begin
      if (m_by < STP) begin m_by = 0; m_dy = 1'b1; end
      else m_by = m_by - STP;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // One pixel per clock. Expected output is queued now and popped after the
  // edge; the queue holds one older entry, giving the two-clock latency.
  task automatic step(input logic d, input int h, input int v, input logic [2:0] sel,
                      input logic [23:0] solid, input bit use_const, input logic [23:0] const_rgb);
    exp_t e;
    exp_t got;
    de = d; hcount = h[11:0]; vcount = v[11:0]; mode_sel = sel; solid_rgb = solid;
    if (d && h == 0 && v == 0) m_mode = sel;
    e.dv = d; e.h = h; e.v = v;
    if (!d)             e.rgb = 24'h0;
    else if (use_const) e.rgb = const_rgb;
    else                e.rgb = model_pixel(h, v, m_mode, solid, m_bx, m_by);
    sb_q.push_back(e);
    if (d && h == H - 1 && v == V - 1) box_move();
    @(posedge clk);
    #1;
    check("mode_active", 32'(ma24), 32'(m_mode));
    check("mode_active565", 32'(ma16), 32'(m_mode));
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      got = sb_q.pop_front();
      check($sformatf("valid@(%0d,%0d)", got.h, got.v), 32'(dv24), 32'(got.dv));
      check($sformatf("valid565@(%0d,%0d)", got.h, got.v), 32'(dv16), 32'(got.dv));
      check($sformatf("rgb888@(%0d,%0d)", got.h, got.v), 32'(dd24), 32'(got.rgb));
      check($sformatf("rgb565@(%0d,%0d)", got.h, got.v), 32'(dd16), 32'(to565(got.rgb)));
    end
    $display("pixel de=%0b (%0d,%0d) sel=%0d -> out=%06h/%04h valid=%0b mode=%0d",
             d, h, v, sel, dd24, dd16, dv24, ma24);
  endtask

  task automatic do_reset(input logic d, input int h, input int v);
    exp_t z;
    reset = 1'b1; de = d; hcount = h[11:0]; vcount = v[11:0];
    @(posedge clk);
    #1;
    check("reset_data888", 32'(dd24), 32'h0);
    check("reset_data565", 32'(dd16), 32'h0);
    check("reset_valid", 32'(dv24), 32'h0);
    check("reset_valid565", 32'(dv16), 32'h0);
    check("reset_mode", 32'(ma24), 32'h0);
    $display("reset applied: out=%06h valid=%0b mode=%0d", dd24, dv24, ma24);
    reset = 1'b0;
    m_mode = '0; m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1;
    sb_q.delete();
    z = '{dv: 1'b0, rgb: 24'h0, h: -1, v: -1};
    sb_q.push_back(z);
  endtask

  function automatic void add(input logic d, input int h, input int v, input logic [2:0] sel,
                              input logic [23:0] solid, input logic [23:0] rgb, input logic [2:0] mode);
    vec_t t;
    t = '{d: d, h: h, v: v, sel: sel, solid: solid, rgb: rgb, mode: mode};
    tbl.push_back(t);
  endfunction

  task automatic frame_end_step();
    step(1'b1, H - 1, V - 1, 3'd3, 24'h0, 1'b0, 24'h0);
  endtask

  // First three frames of mode 3 after reset: box at (0,0), (4,4), (8,8).
  task automatic box_first_frames();
    step(1'b1, 0, 0, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    step(1'b1, 63, 63, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    step(1'b1, 64, 0, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 0, 64, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, H - 1, V - 1, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 0, 0, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 3, 3, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 4, 4, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    step(1'b1, 67, 67, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    step(1'b1, 68, 67, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, H - 1, V - 1, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 0, 0, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 7, 7, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 8, 8, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    frame_end_step();
  endtask

  initial begin
    //  de  h     v     sel   solid        expected     mode
    add(1,  0,    0,    0, 24'h000000, 24'h000000, 0);
    add(1,  100,  100,  0, 24'h000000, 24'h000000, 0);
    add(1,  700,  100,  0, 24'h000000, 24'h0000FF, 0);
    add(1,  100,  200,  0, 24'h000000, 24'hFF0000, 0);
    add(1,  1279, 719,  0, 24'h000000, 24'hFFFFFF, 0);
    add(0,  0,    0,    0, 24'h000000, 24'h000000, 0);
    add(1,  600,  300,  1, 24'h000000, 24'hFF0000, 0);
    add(1,  0,    0,    1, 24'h000000, 24'h000000, 1);
    add(1,  32,   0,    1, 24'h000000, 24'hFFFFFF, 1);
    add(1,  32,   32,   1, 24'h000000, 24'h000000, 1);
    add(1,  1279, 719,  1, 24'h000000, 24'hFFFFFF, 1);
    add(1,  0,    0,    2, 24'h000000, 24'h000000, 2);
    add(1,  640,  0,    2, 24'h000000, 24'h7F7F7F, 2);
    add(1,  1279, 5,    2, 24'h000000, 24'hFEFEFE, 2);
    add(1,  640,  500,  2, 24'h000000, 24'h7F7F7F, 2);
    add(1,  255,  300,  2, 24'h000000, 24'h323232, 2);
    add(1,  0,    0,    3, 24'h000000, 24'h0000FF, 3);
    add(1,  8,    8,    3, 24'h000000, 24'hFFFFFF, 3);
    add(1,  71,   71,   3, 24'h000000, 24'hFFFFFF, 3);
    add(1,  72,   8,    3, 24'h000000, 24'h0000FF, 3);
    add(1,  1279, 719,  3, 24'h000000, 24'h0000FF, 3);
    add(1,  0,    0,    4, 24'hFF8040, 24'hFF8040, 4);
    add(0,  5,    5,    4, 24'hFF8040, 24'h000000, 4);
    add(1,  5,    5,    4, 24'h123456, 24'h123456, 4);
    add(1,  0,    0,    5, 24'h123456, 24'h000000, 5);
    add(1,  1279, 719,  7, 24'h123456, 24'h000000, 5);
    add(1,  0,    0,    0, 24'h000000, 24'h000000, 0);
    add(1,  2000, 3000, 0, 24'h000000, 24'hFFFFFF, 0);
    add(1,  1279, 720,  0, 24'h000000, 24'hFFFFFF, 0);
    add(1,  640,  719,  0, 24'h000000, 24'hFFFFFF, 0);
    add(1,  639,  180,  0, 24'h000000, 24'hFF0000, 0);
    add(1,  640,  179,  0, 24'h000000, 24'h0000FF, 0);
    add(1,  0,    0,    3, 24'h000000, 24'h0000FF, 3);
    add(1,  16,   16,   3, 24'h000000, 24'hFFFFFF, 3);
    add(1,  15,   16,   3, 24'h000000, 24'h0000FF, 3);

    do_reset(1'b0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].d, tbl[i].h, tbl[i].v, tbl[i].sel, tbl[i].solid, 1'b1, tbl[i].rgb);
      check($sformatf("row%0d_mode", i), 32'(ma24), 32'(tbl[i].mode));
    end

    // Bouncing box from reset up to the right-hand wall
    do_reset(1'b1, 0, 0);
    box_first_frames();
    for (int f = 3; f < 303; f++) begin
      step(1'b1, 0, 0, 3'd3, 24'h0, 1'b0, 24'h0);
      step(1'b1, m_bx, m_by, 3'd3, 24'h0, 1'b0, 24'h0);
      step(1'b1, m_bx + BOX, m_by + BOX - 1, 3'd3, 24'h0, 1'b0, 24'h0);
      step(1'b1, $urandom_range(0, H - 2), $urandom_range(0, V - 1), 3'd3, 24'h0, 1'b0, 24'h0);
      frame_end_step();
    end
    // box (1212,104) moving right
    step(1'b1, 0, 0, 3'd3, 24'h0, 1'b0, 24'h0);
    step(1'b1, 1212, 104, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    step(1'b1, 1211, 104, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    frame_end_step();
    // box (1216,100): reached the wall
    step(1'b1, 0, 0, 3'd3, 24'h0, 1'b0, 24'h0);
    step(1'b1, 1216, 100, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    step(1'b1, 1215, 100, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 1279, 163, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    frame_end_step();
    // box (1216,96): clamped, direction reversed
    step(1'b1, 0, 0, 3'd3, 24'h0, 1'b0, 24'h0);
    step(1'b1, 1216, 96, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    step(1'b1, 1215, 96, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    frame_end_step();
    // box (1212,92): moving left
    step(1'b1, 0, 0, 3'd3, 24'h0, 1'b0, 24'h0);
    step(1'b1, 1212, 92, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    step(1'b1, 1211, 92, 3'd3, 24'h0, 1'b1, 24'h0000FF);
    step(1'b1, 1276, 92, 3'd3, 24'h0, 1'b1, 24'h0000FF);

    // Mid-frame reset in mode 3 with the pipeline full
    step(1'b1, 500, 300, 3'd3, 24'h0, 1'b0, 24'h0);
    step(1'b1, m_bx, m_by, 3'd3, 24'h0, 1'b1, 24'hFFFFFF);
    do_reset(1'b1, 600, 300);
    box_first_frames();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
